csr_access_unit: RTL

- Execute-stage sequencer for Zicsr instructions (CSRRW/CSRRS/CSRRC and the immediate forms). It sits between decode and the CSR file.
- Accepts one decoded CSR op over a valid/ready handshake and applies the x0/zero-immediate side-effect rules and the privilege/read-only checks.
- Drives the CSR file's read and write strobes in separate cycles and computes the read-modify-write value.
- Returns the old CSR value (or an illegal-instruction flag) to writeback over a second valid/ready handshake.

---
 rtl/csr_pkg.sv | 45 ++++
 rtl/csr_access_check.sv | 31 +++
 rtl/csr_access_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared types and helpers for the Zicsr execute-stage sequencer.
package csr_pkg;

  localparam int CSR_XLEN   = 32;
  localparam int CSR_ADDR_W = 12;

  typedef enum logic [1:0] {
    WF_ILL = 2'b00,
    WF_RW  = 2'b01,
    WF_RS  = 2'b10,
    WF_RC  = 2'b11
  } csr_write_func_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } csr_access_state_t;

  typedef struct packed {
    logic [1:0]            write_func;
    logic [CSR_ADDR_W-1:0] addr;
    logic [CSR_XLEN-1:0]   src;
    logic [4:0]            rd;
    logic                  do_read;
    logic                  do_write;
  } csr_op_t;

  function automatic logic [CSR_XLEN-1:0] csr_rmw(
    input logic [1:0]          write_func,
    input logic [CSR_XLEN-1:0] old,
    input logic [CSR_XLEN-1:0] src
  );
    logic [CSR_XLEN-1:0] res;
    case (write_func)
      WF_RW:   res = src;
      WF_RS:   res = old | src;
      WF_RC:   res = old & ~src;
      default: res = old;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_access_check.sv
// Combinational side-effect and legality rules for a Zicsr op; shared with decode.
module csr_access_check
  import csr_pkg::*;
(
  input  logic [1:0] write_func_i,
  input  logic [4:0] rs1_idx_i,
  input  logic [4:0] rd_idx_i,
  input  logic [3:0] addr_hi_i,
  input  logic [1:0] priv_mode_i,
  output logic       do_read_o,
  output logic       do_write_o,
  output logic       illegal_o
);

  // Gating uses register indices, never register values.
  always_comb begin
    do_read_o  = 1'b1;
    do_write_o = 1'b0;
    illegal_o  = 1'b0;
    if ((write_func_i == WF_RW) && (rd_idx_i == 5'd0)) begin
      do_read_o = 1'b0;
    end else begin
      do_read_o = 1'b1;
    end
    do_write_o = (write_func_i == WF_RW) || (rs1_idx_i != 5'd0);
    illegal_o  = (write_func_i == WF_ILL) ||
                 (priv_mode_i < addr_hi_i[1:0]) ||
                 (do_write_o && (addr_hi_i[3:2] == 2'b11));
  end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr execute sequencer: accepts a decoded op, strobes the CSR file for read
// then write in separate cycles, and returns the old value to writeback.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int XLEN   = CSR_XLEN,
  parameter int ADDR_W = CSR_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_funct3,
  input  logic [ADDR_W-1:0] op_csr_addr,
  input  logic [4:0]        op_rs1_idx,
  input  logic [XLEN-1:0]   op_rs1_val,
  input  logic [4:0]        op_rd_idx,
  input  logic [1:0]        priv_mode,
  output logic [ADDR_W-1:0] csr_addr,
  output logic              csr_read_en,
  output logic              csr_write_en,
  output logic [XLEN-1:0]   csr_write_data,
  input  logic [XLEN-1:0]   csr_read_data,
  input  logic              csr_illegal,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd_idx,
  output logic [XLEN-1:0]   wb_result,
  output logic              wb_illegal
);

  csr_access_state_t state_q;
  csr_op_t           op_q;
  logic [XLEN-1:0]   old_q;
  logic              op_ready_q;
  logic              read_en_q;
  logic              write_en_q;
  logic [XLEN-1:0]   write_data_q;
  logic              wb_valid_q;
  logic [4:0]        wb_rd_idx_q;
  logic [XLEN-1:0]   wb_result_q;
  logic              wb_illegal_q;

  logic [XLEN-1:0]   src_s;
  logic              chk_do_read_s;
  logic              chk_do_write_s;
  logic              chk_illegal_s;

  assign src_s = op_funct3[2] ? {{(XLEN-5){1'b0}}, op_rs1_idx} : op_rs1_val;

  csr_access_check u_check (
    .write_func_i (op_funct3[1:0]),
    .rs1_idx_i    (op_rs1_idx),
    .rd_idx_i     (op_rd_idx),
    .addr_hi_i    (op_csr_addr[11:8]),
    .priv_mode_i  (priv_mode),
    .do_read_o    (chk_do_read_s),
    .do_write_o   (chk_do_write_s),
    .illegal_o    (chk_illegal_s)
  );

  // Sequencer FSM; every output below is a register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      old_q        <= '0;
      op_ready_q   <= 1'b1;
      read_en_q    <= 1'b0;
      write_en_q   <= 1'b0;
      write_data_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_idx_q  <= 5'd0;
      wb_result_q  <= '0;
      wb_illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_valid && op_ready_q) begin
            op_q       <= '{write_func: op_funct3[1:0], addr: op_csr_addr, src: src_s,
                            rd: op_rd_idx, do_read: chk_do_read_s, do_write: chk_do_write_s};
            op_ready_q <= 1'b0;
            if (chk_illegal_s) begin
              state_q      <= RESP;
              wb_valid_q   <= 1'b1;
              wb_illegal_q <= 1'b1;
              wb_result_q  <= '0;
              wb_rd_idx_q  <= chk_do_read_s ? op_rd_idx : 5'd0;
            end else if (chk_do_read_s) begin
              state_q   <= READ;
              read_en_q <= 1'b1;
            end else begin
              state_q      <= WRITE;
              write_en_q   <= 1'b1;
              write_data_q <= src_s;
            end
          end
        end
        READ: begin
          read_en_q <= 1'b0;
          old_q     <= csr_read_data;
          if (csr_illegal) begin
            state_q      <= RESP;
            wb_valid_q   <= 1'b1;
            wb_illegal_q <= 1'b1;
            wb_result_q  <= '0;
            wb_rd_idx_q  <= op_q.rd;
          end else if (op_q.do_write) begin
            state_q      <= WRITE;
            write_en_q   <= 1'b1;
            write_data_q <= csr_rmw(op_q.write_func, csr_read_data, op_q.src);
          end else begin
            state_q      <= RESP;
            wb_valid_q   <= 1'b1;
            wb_illegal_q <= 1'b0;
            wb_result_q  <= csr_read_data;
            wb_rd_idx_q  <= op_q.rd;
          end
        end
        WRITE: begin
          write_en_q   <= 1'b0;
          state_q      <= RESP;
          wb_valid_q   <= 1'b1;
          wb_illegal_q <= csr_illegal;
          wb_result_q  <= (csr_illegal || !op_q.do_read) ? '0 : old_q;
          wb_rd_idx_q  <= op_q.do_read ? op_q.rd : 5'd0;
        end
        RESP: begin
          if (wb_ready) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
            op_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          read_en_q  <= 1'b0;
          write_en_q <= 1'b0;
          wb_valid_q <= 1'b0;
          op_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign op_ready       = op_ready_q;
  assign csr_addr       = op_q.addr;
  assign csr_read_en    = read_en_q;
  assign csr_write_en   = write_en_q;
  assign csr_write_data = write_data_q;
  assign wb_valid       = wb_valid_q;
  assign wb_rd_idx      = wb_rd_idx_q;
  assign wb_result      = wb_result_q;
  assign wb_illegal     = wb_illegal_q;

endmodule
